multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer that drives the register-file/ALU datapath of the RISC-V core. It fetches one 32-bit instruction at a time over a ready-handshake instruction-memory port. It decodes an RV32I subset and presents the register addresses, write enable, ALU control, immediate and operand-select signals to the datapath. It consumes the datapath's `EQ` flag to resolve branches and owns the program counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `A_WIDTH`, default 5: register address width.
- `D_WIDTH`, default 32: data, PC and instruction width.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `imem_req`  output  1  fetch request; high only in FETCH.
- `imem_addr`  output  D_WIDTH  fetch address, equal to `pc`.
- `imem_ready`  input  1  instruction valid this cycle.
- `imem_rdata`  input  D_WIDTH  instruction word.
- `rs1`, `rs2`, `rd`  output  A_WIDTH each  register addresses to the datapath.
- `RegWrite`  output  1  register write enable.
- `ALUsrc`  output  1  0 selects `rs2` data, 1 selects `ImmOp`.
- `ALUctrl`  output  3  ALU operation: 3'b000 add, 3'b001 sub; all other codes are never driven.
- `ImmOp`  output  D_WIDTH  sign-extended immediate.
- `EQ`  input  1  ALU operands equal (valid in EXEC).
- `pc`  output  D_WIDTH  current program counter.
- `retire`  output  1  one-cycle pulse per completed instruction.
- `illegal`  output  1  sticky: an unsupported instruction was decoded; core halted.

## Operation
- Supported instructions; any other encoding is illegal:
  - ADDI: opcode 0010011, funct3 000.
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
  - SUB: opcode 0110011, funct3 000, funct7 0100000.
  - BEQ: opcode 1100011, funct3 000.
  - BNE: opcode 1100011, funct3 001.
- Decode:
  - ADDI: ALUsrc=1, ALUctrl=000, ImmOp=sext(ir[31:20]).
  - ADD/SUB: ALUsrc=0, ALUctrl=000 for ADD, 001 for SUB, ImmOp=0.
  - BEQ/BNE: ALUsrc=0, ALUctrl=001, ImmOp=sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}).
- rs1=ir[19:15], rs2=ir[24:20], rd=ir[11:7] are registered at DECODE exit. For branches, rd is driven to 0.
- FSM states are FETCH, DECODE, EXEC, WB, HALT. Transitions:
  - FETCH: imem_req=1. On `imem_ready`, latch `imem_rdata` into ir and go to DECODE. Otherwise stay in FETCH.
  - DECODE: register all control outputs. Illegal encoding -> HALT and set `illegal`. Otherwise -> EXEC.
  - EXEC: datapath operands are stable.
    - ADDI/ADD/SUB -> WB.
    - Branch: sample `EQ`. Taken if (BEQ && EQ) or (BNE && !EQ). Taken: pc <= pc + ImmOp. Not taken: pc <= pc + 4. Pulse `retire`, then -> FETCH.
  - WB: RegWrite=1 unless rd==0, in which case RegWrite=0. Set pc <= pc + 4, pulse `retire`, -> FETCH.
  - HALT: terminal until reset. All outputs hold, except imem_req=0 and RegWrite=0.
- PC arithmetic is modulo 2^D_WIDTH; wrap-around at 32'hFFFF_FFFC + 4 gives 0.
- No alignment check is made on branch targets; bit 0 is always 0 by construction.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0 while in reset; imem_req=1 in the first cycle after release.
  - rs1/rs2/rd/ALUctrl/ALUsrc/RegWrite/retire/illegal=0, ImmOp=0.
- Reset mid-instruction abandons the instruction with no register write and no PC update.
- Latency with zero-wait memory (`imem_ready` high in the request cycle):
  - ALU instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branches: 3 cycles.
  - Each cycle `imem_ready` stays low adds one cycle.
- `imem_addr` is stable while `imem_req` is high. `imem_rdata` is sampled only on the edge where `imem_req && imem_ready`. `imem_ready` outside FETCH is ignored.
- Control outputs change only on the DECODE->EXEC edge and hold through EXEC and WB.
- RegWrite is high for exactly the one WB cycle.
- `retire` is high in the cycle after pc updates, for one cycle.
- `illegal` rises on the DECODE->HALT edge.

## Test plan
- Reset then ADDI x1,x0,5 (32'h00500093) with zero-wait memory:
  - rs1=0, rd=1, ImmOp=5, ALUsrc=1, ALUctrl=000.
  - RegWrite high in cycle 4 only.
  - pc goes 0->4.
  - retire pulses once.
- SUB x3,x1,x2 (32'h402081B3) with imem_ready delayed 3 cycles: FETCH lasts 4 cycles, ALUctrl=001, ALUsrc=0, RegWrite in the WB cycle.
- BNE at pc=8, offset -8 (32'hFE209CE3):
  - EQ=0: pc=0, no RegWrite.
  - EQ=1: pc=12.
  - Each case takes 3 cycles.
- ADD x0,x1,x2 (32'h00208033): full 4-cycle sequence, RegWrite stays 0, pc+4.
- Illegal word 32'hFFFFFFFF: illegal=1, imem_req stays 0 for 20 cycles, pc unchanged. Assert rst_n=0 and check illegal clears asynchronously and pc=RESET_PC.
- rst_n pulsed low during EXEC of an ADDI: no RegWrite pulse, pc=RESET_PC, refetch starts the cycle after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control sequencer: fetch, decode, branch resolution, PC ownership.
// Latency: ALU ops 4 cycles, branches 3 cycles, plus one cycle per fetch cycle without imem_ready.
// Backpressure: holds in FETCH with imem_req high and imem_addr stable until imem_ready.
module multicycle_control #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 5,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic [A_WIDTH-1:0] rs1,
    output logic [A_WIDTH-1:0] rs2,
    output logic [A_WIDTH-1:0] rd,
    output logic               RegWrite,
    output logic               ALUsrc,
    output logic [2:0]         ALUctrl,
    output logic [D_WIDTH-1:0] ImmOp,
    input  logic               EQ,
    output logic [D_WIDTH-1:0] pc,
    output logic               retire,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [D_WIDTH-1:0]   r_ir;
    logic [D_WIDTH-1:0]   r_pc;
    logic [A_WIDTH-1:0]   r_rs1;
    logic [A_WIDTH-1:0]   r_rs2;
    logic [A_WIDTH-1:0]   r_rd;
    logic                 r_alusrc;
    logic [2:0]           r_aluctrl;
    logic [D_WIDTH-1:0]   r_imm;
    logic                 r_is_branch;
    logic                 r_is_bne;
    logic                 r_retire;
    logic                 r_illegal;

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic                 w_is_addi;
    logic                 w_is_add;
    logic                 w_is_sub;
    logic                 w_is_beq;
    logic                 w_is_bne;
    logic                 w_is_branch;
    logic                 w_legal;
    logic [D_WIDTH-1:0]   w_imm_i;
    logic [D_WIDTH-1:0]   w_imm_b;
    logic [D_WIDTH-1:0]   w_dec_imm;
    logic [2:0]           w_dec_aluctrl;
    logic                 w_dec_alusrc;
    logic [D_WIDTH-1:0]   w_pc_plus4;
    logic [D_WIDTH-1:0]   w_pc_target;
    logic                 w_taken;
    logic                 w_fetch_accept;

    // Instruction field decode, always from the latched instruction register.
    always_comb begin
        w_opcode    = r_ir[6:0];
        w_funct3    = r_ir[14:12];
        w_funct7    = r_ir[31:25];

        w_is_addi   = (w_opcode == OP_IMM) && (w_funct3 == 3'b000);
        w_is_add    = (w_opcode == OP_REG) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
        w_is_sub    = (w_opcode == OP_REG) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
        w_is_beq    = (w_opcode == OP_BRANCH) && (w_funct3 == 3'b000);
        w_is_bne    = (w_opcode == OP_BRANCH) && (w_funct3 == 3'b001);
        w_is_branch = w_is_beq || w_is_bne;
        w_legal     = w_is_addi || w_is_add || w_is_sub || w_is_branch;

        w_imm_i = {{(D_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
        w_imm_b = {{(D_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

        w_dec_imm     = '0;
        w_dec_aluctrl = ALU_ADD;
        w_dec_alusrc  = 1'b0;
        if (w_is_addi) begin
            w_dec_imm    = w_imm_i;
            w_dec_alusrc = 1'b1;
        end else if (w_is_sub) begin
            w_dec_aluctrl = ALU_SUB;
        end else if (w_is_branch) begin
            w_dec_imm     = w_imm_b;
            w_dec_aluctrl = ALU_SUB;
        end
    end

    always_comb begin
        w_pc_plus4     = r_pc + D_WIDTH'(4);
        w_pc_target    = r_pc + r_imm;
        w_taken        = r_is_bne ? !EQ : EQ;
        w_fetch_accept = (r_state == S_FETCH) && imem_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_state_nxt = r_is_branch ? S_FETCH : S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir        <= '0;
            r_pc        <= RESET_PC;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alusrc    <= 1'b0;
            r_aluctrl   <= ALU_ADD;
            r_imm       <= '0;
            r_is_branch <= 1'b0;
            r_is_bne    <= 1'b0;
            r_retire    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            if (w_fetch_accept) begin
                r_ir <= imem_rdata;
            end
            // Control outputs only move on the DECODE->EXEC edge; an illegal word leaves them untouched.
            if (r_state == S_DECODE) begin
                if (w_legal) begin
                    r_rs1       <= A_WIDTH'(r_ir[19:15]);
                    r_rs2       <= A_WIDTH'(r_ir[24:20]);
                    r_rd        <= w_is_branch ? '0 : A_WIDTH'(r_ir[11:7]);
                    r_alusrc    <= w_dec_alusrc;
                    r_aluctrl   <= w_dec_aluctrl;
                    r_imm       <= w_dec_imm;
                    r_is_branch <= w_is_branch;
                    r_is_bne    <= w_is_bne;
                end else begin
                    r_illegal   <= 1'b1;
                end
            end
            if ((r_state == S_EXEC) && r_is_branch) begin
                r_pc     <= w_taken ? w_pc_target : w_pc_plus4;
                r_retire <= 1'b1;
            end
            if (r_state == S_WB) begin
                r_pc     <= w_pc_plus4;
                r_retire <= 1'b1;
            end
        end
    end

    // Request is masked while reset is held since the state register already reads FETCH.
    assign imem_req  = (r_state == S_FETCH) && rst_n;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign RegWrite  = (r_state == S_WB) && (r_rd != '0);
    assign ALUsrc    = r_alusrc;
    assign ALUctrl   = r_aluctrl;
    assign ImmOp     = r_imm;
    assign retire    = r_retire;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions with hand-derived expectations,
// scoreboard queue filled at fetch acceptance and drained on retire, plus halt/reset sequences.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic [31:0] ImmOp;
    logic        EQ;
    logic [31:0] pc;
    logic        retire;
    logic        illegal;

    multicycle_control #(.D_WIDTH(32), .A_WIDTH(5), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp),
        .EQ(EQ), .pc(pc), .retire(retire), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          waitc;
        logic        eq;
        logic [31:0] fpc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic [2:0]  ctrl;
        logic [31:0] imm;
        int          rw;
        logic [31:0] npc;
        int          cycles;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];
    vec_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [31:0] instr, input int waitc, input logic eq,
                                input logic [31:0] fpc, input logic [4:0] e_rs1,
                                input logic [4:0] e_rs2, input logic [4:0] e_rd,
                                input logic alusrc, input logic [2:0] ctrl,
                                input logic [31:0] imm, input int rw,
                                input logic [31:0] npc, input int cycles);
        vec_t v;
        v.instr = instr; v.waitc = waitc; v.eq = eq; v.fpc = fpc;
        v.rs1 = e_rs1; v.rs2 = e_rs2; v.rd = e_rd; v.alusrc = alusrc; v.ctrl = ctrl;
        v.imm = imm; v.rw = rw; v.npc = npc; v.cycles = cycles;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int k);
        vec_t v = tbl[k];
        int   cyc = 0;
        int   rw_n = 0;
        int   rw_at = -1;
        bit   done = 0;
        bit   accepted = 0;
        while (!done && cyc < 60) begin
            if (cyc > 0 && retire) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL v%0d spurious_retire: got retire=1, expected no pending instruction", k);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk($sformatf("v%0d pc", k), pc, e.npc);
                    chk($sformatf("v%0d cycles", k), cyc, e.cycles);
                    chk($sformatf("v%0d rs1", k), {27'd0, rs1}, {27'd0, e.rs1});
                    chk($sformatf("v%0d rs2", k), {27'd0, rs2}, {27'd0, e.rs2});
                    chk($sformatf("v%0d rd", k), {27'd0, rd}, {27'd0, e.rd});
                    chk($sformatf("v%0d ALUsrc", k), {31'd0, ALUsrc}, {31'd0, e.alusrc});
                    chk($sformatf("v%0d ALUctrl", k), {29'd0, ALUctrl}, {29'd0, e.ctrl});
                    chk($sformatf("v%0d ImmOp", k), ImmOp, e.imm);
                    chk($sformatf("v%0d regwrite_cycles", k), rw_n, e.rw);
                    if (e.rw == 1) chk($sformatf("v%0d regwrite_pos", k), rw_at, e.cycles - 1);
                end
                done = 1;
            end
            if (!done) begin
                if (imem_req) begin
                    if (!accepted && cyc >= v.waitc) begin
                        chk($sformatf("v%0d imem_addr", k), imem_addr, v.fpc);
                        imem_ready = 1'b1;
                        imem_rdata = v.instr;
                        sb.push_back(v);
                        accepted = 1;
                    end else begin
                        imem_ready = 1'b0;
                        imem_rdata = $urandom;
                    end
                end else begin
                    // Garbage on the fetch port outside FETCH must be ignored.
                    imem_ready = 1'($urandom_range(0, 1));
                    imem_rdata = $urandom;
                end
                EQ = v.eq;
                if (RegWrite) begin
                    rw_n++;
                    rw_at = cyc;
                end
                tick();
                cyc++;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL v%0d timeout: no retire after %0d cycles, expected %0d", k, cyc, v.cycles);
        end
    endtask

    initial begin
        int req_n;
        int rw_n;
        int ret_n;

        tbl[0] = mk(32'h00500093, 0, 1'b0, 32'h0000_0000, 5'd0, 5'd5,  5'd1, 1'b1, 3'b000, 32'h0000_0005, 1, 32'h0000_0004, 4);
        tbl[1] = mk(32'h402081B3, 3, 1'b0, 32'h0000_0004, 5'd1, 5'd2,  5'd3, 1'b0, 3'b001, 32'h0000_0000, 1, 32'h0000_0008, 7);
        tbl[2] = mk(32'hFE209CE3, 0, 1'b0, 32'h0000_0008, 5'd1, 5'd2,  5'd0, 1'b0, 3'b001, 32'hFFFF_FFF8, 0, 32'h0000_0000, 3);
        tbl[3] = mk(32'h00208033, 0, 1'b1, 32'h0000_0000, 5'd1, 5'd2,  5'd0, 1'b0, 3'b000, 32'h0000_0000, 0, 32'h0000_0004, 4);
        tbl[4] = mk(32'hFFF08113, 1, 1'b1, 32'h0000_0004, 5'd1, 5'd31, 5'd2, 1'b1, 3'b000, 32'hFFFF_FFFF, 1, 32'h0000_0008, 5);
        tbl[5] = mk(32'hFE209CE3, 0, 1'b1, 32'h0000_0008, 5'd1, 5'd2,  5'd0, 1'b0, 3'b001, 32'hFFFF_FFF8, 0, 32'h0000_000C, 3);
        tbl[6] = mk(32'h00208863, 2, 1'b1, 32'h0000_000C, 5'd1, 5'd2,  5'd0, 1'b0, 3'b001, 32'h0000_0010, 0, 32'h0000_001C, 5);
        tbl[7] = mk(32'h00208863, 0, 1'b0, 32'h0000_001C, 5'd1, 5'd2,  5'd0, 1'b0, 3'b001, 32'h0000_0010, 0, 32'h0000_0020, 3);
        tbl[8] = mk(32'hFC000EE3, 0, 1'b1, 32'h0000_0020, 5'd0, 5'd0,  5'd0, 1'b0, 3'b001, 32'hFFFF_FFDC, 0, 32'hFFFF_FFFC, 3);
        tbl[9] = mk(32'h00500093, 0, 1'b0, 32'hFFFF_FFFC, 5'd0, 5'd5,  5'd1, 1'b1, 3'b000, 32'h0000_0005, 1, 32'h0000_0000, 4);

        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        EQ = 1'b0;
        #12;
        chk("rst imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst pc", pc, 32'h0);
        chk("rst regs", {17'd0, rs1, rs2, rd}, 32'd0);
        chk("rst ctrl", {26'd0, ALUctrl, ALUsrc, RegWrite, retire}, 32'd0);
        chk("rst illegal", {31'd0, illegal}, 32'd0);
        chk("rst ImmOp", ImmOp, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("release imem_req", {31'd0, imem_req}, 32'd1);

        for (int k = 0; k < NVEC; k++) run_vec(k);

        // Illegal word at pc 0: halt, request dropped, outputs held.
        chk("ill imem_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("ill in decode", {31'd0, illegal}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h00500093;
        tick();
        chk("ill raised", {31'd0, illegal}, 32'd1);
        req_n = 0; rw_n = 0; ret_n = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            req_n += int'(imem_req);
            rw_n  += int'(RegWrite);
            ret_n += int'(retire);
            tick();
        end
        chk("halt imem_req cycles", req_n, 0);
        chk("halt regwrite cycles", rw_n, 0);
        chk("halt retire cycles", ret_n, 0);
        chk("halt pc", pc, 32'h0);
        chk("halt ImmOp held", ImmOp, 32'h5);
        chk("halt rd held", {27'd0, rd}, 32'd1);
        chk("halt illegal sticky", {31'd0, illegal}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async clr illegal", {31'd0, illegal}, 32'd0);
        chk("async clr pc", pc, 32'h0);
        chk("async imem_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        run_vec(0);

        // Reset asserted during EXEC of ADDI x1,x0,5 fetched at pc 4.
        chk("rexec imem_addr", imem_addr, 32'h4);
        imem_ready = 1'b1;
        imem_rdata = 32'h00500093;
        tick();
        imem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        rw_n = 0; ret_n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            rw_n  += int'(RegWrite);
            ret_n += int'(retire);
            tick();
        end
        chk("rexec regwrite", rw_n, 0);
        chk("rexec retire", ret_n, 0);
        chk("rexec pc", pc, 32'h0);
        chk("rexec rd cleared", {27'd0, rd}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rexec refetch req", {31'd0, imem_req}, 32'd1);
        run_vec(0);
        chk("sb empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
